// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32 pipeline: opcodes, ALU/result-select codes,
// immediate formats and the decoded control bundle.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // IMM_NONE yields a zero immediate (R-type and illegal encodings).
    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_J    = 3'd4
    } imm_src_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       alu_src;
        logic [1:0] result_src;
        logic [2:0] alu_control;
        imm_src_e   imm_src;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/control_unit.sv
// Main decoder: opcode/funct3/funct7[5] to control bundle. Any encoding not
// listed below yields all-zero controls with illegal set.
module control_unit
    import riscv_pkg::*;
(
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (op_i)
            OP_LOAD: begin
                if (funct3_i == 3'b010) begin
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.alu_src    = 1'b1;
                    ctrl_o.result_src = RES_MEM;
                    ctrl_o.imm_src    = IMM_I;
                end else begin
                    ctrl_o.illegal = 1'b1;
                end
            end
            OP_STORE: begin
                if (funct3_i == 3'b010) begin
                    ctrl_o.mem_write = 1'b1;
                    ctrl_o.alu_src   = 1'b1;
                    ctrl_o.imm_src   = IMM_S;
                end else begin
                    ctrl_o.illegal = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (funct3_i == 3'b000) begin
                    ctrl_o.branch      = 1'b1;
                    ctrl_o.alu_control = ALU_SUB;
                    ctrl_o.imm_src     = IMM_B;
                end else begin
                    ctrl_o.illegal = 1'b1;
                end
            end
            OP_JAL: begin
                ctrl_o.jump       = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.result_src = RES_PC4;
                ctrl_o.imm_src    = IMM_J;
            end
            OP_RTYPE: begin
                ctrl_o.reg_write = 1'b1;
                case ({funct7b5_i, funct3_i})
                    4'b0_000: ctrl_o.alu_control = ALU_ADD;
                    4'b1_000: ctrl_o.alu_control = ALU_SUB;
                    4'b0_111: ctrl_o.alu_control = ALU_AND;
                    4'b0_110: ctrl_o.alu_control = ALU_OR;
                    4'b0_010: ctrl_o.alu_control = ALU_SLT;
                    default: begin
                        ctrl_o         = '0;
                        ctrl_o.illegal = 1'b1;
                    end
                endcase
            end
            OP_IALU: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.imm_src   = IMM_I;
                case (funct3_i)
                    3'b000:  ctrl_o.alu_control = ALU_ADD;
                    3'b111:  ctrl_o.alu_control = ALU_AND;
                    3'b110:  ctrl_o.alu_control = ALU_OR;
                    3'b010:  ctrl_o.alu_control = ALU_SLT;
                    default: begin
                        ctrl_o         = '0;
                        ctrl_o.illegal = 1'b1;
                    end
                endcase
            end
            default: ctrl_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage plus ID/EX register: control decode, immediate extension,
// writeback bypass around the register file and load-use stall detection.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    output logic [4:0]      A1,
    output logic [4:0]      A2,
    input  logic [XLEN-1:0] RD1,
    input  logic [XLEN-1:0] RD2,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            FlushE,
    output logic            StallD,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            BranchE,
    output logic            JumpE,
    output logic            ALUSrcE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic            IllegalE
);

    typedef struct packed {
        logic            reg_write;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic            alu_src;
        logic [1:0]      result_src;
        logic [2:0]      alu_control;
        logic            illegal;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } ex_t;

    ctrl_t           ctrl;
    logic [XLEN-1:0] imm_d;
    logic [XLEN-1:0] rd1_d;
    logic [XLEN-1:0] rd2_d;
    ex_t             ex_d;
    ex_t             ex_q;

    assign A1 = InstrD[19:15];
    assign A2 = InstrD[24:20];

    control_unit u_control (
        .op_i      (InstrD[6:0]),
        .funct3_i  (InstrD[14:12]),
        .funct7b5_i(InstrD[30]),
        .ctrl_o    (ctrl)
    );

    always_comb begin
        imm_d = '0;
        case (ctrl.imm_src)
            IMM_I: imm_d = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
            IMM_S: imm_d = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B: imm_d = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7],
                            InstrD[30:25], InstrD[11:8], 1'b0};
            IMM_J: imm_d = {{(XLEN-21){InstrD[31]}}, InstrD[31], InstrD[19:12],
                            InstrD[20], InstrD[30:21], 1'b0};
            default: imm_d = '0;
        endcase
    end

    // The register file writes on the edge we capture on, so forward W here.
    assign rd1_d = (RegWriteW && (RdW != 5'd0) && (RdW == A1)) ? ResultW : RD1;
    assign rd2_d = (RegWriteW && (RdW != 5'd0) && (RdW == A2)) ? ResultW : RD2;

    // rs2 is compared even for formats without rs2; a spurious stall is harmless.
    assign StallD = (ex_q.result_src == RES_MEM) && (ex_q.rd != 5'd0) &&
                    ((ex_q.rd == A1) || (ex_q.rd == A2));

    always_comb begin
        ex_d = '0;
        if (!(FlushE || StallD)) begin
            ex_d.reg_write   = ctrl.reg_write;
            ex_d.mem_write   = ctrl.mem_write;
            ex_d.branch      = ctrl.branch;
            ex_d.jump        = ctrl.jump;
            ex_d.alu_src     = ctrl.alu_src;
            ex_d.result_src  = ctrl.result_src;
            ex_d.alu_control = ctrl.alu_control;
            ex_d.illegal     = ctrl.illegal;
            ex_d.rd1         = rd1_d;
            ex_d.rd2         = rd2_d;
            ex_d.imm         = imm_d;
            ex_d.pc          = PCD;
            ex_d.pc_plus4    = PCPlus4D;
            ex_d.rs1         = A1;
            ex_d.rs2         = A2;
            ex_d.rd          = InstrD[11:7];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign RegWriteE   = ex_q.reg_write;
    assign MemWriteE   = ex_q.mem_write;
    assign BranchE     = ex_q.branch;
    assign JumpE       = ex_q.jump;
    assign ALUSrcE     = ex_q.alu_src;
    assign ResultSrcE  = ex_q.result_src;
    assign ALUControlE = ex_q.alu_control;
    assign IllegalE    = ex_q.illegal;
    assign RD1E        = ex_q.rd1;
    assign RD2E        = ex_q.rd2;
    assign ImmExtE     = ex_q.imm;
    assign PCE         = ex_q.pc;
    assign PCPlus4E    = ex_q.pc_plus4;
    assign Rs1E        = ex_q.rs1;
    assign Rs2E        = ex_q.rs2;
    assign RdE         = ex_q.rd;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table, reset/hazard sequences and
// randomized traffic against a mnemonic-level reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD, PCD, PCPlus4D, RD1, RD2, ResultW;
    logic [4:0]  A1, A2, RdW;
    logic        RegWriteW, FlushE, StallD;
    logic        RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, IllegalE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .FlushE(FlushE),
        .StallD(StallD), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .BranchE(BranchE), .JumpE(JumpE), .ALUSrcE(ALUSrcE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .IllegalE(IllegalE)
    );

    typedef struct packed {
        logic        reg_write, mem_write, branch, jump, alu_src;
        logic [1:0]  result_src;
        logic [2:0]  alu_ctrl;
        logic        illegal;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rs1, rs2, rd;
    } e_t;

    typedef struct {
        logic [31:0] ins;
        logic        flush, rw;
        logic [4:0]  rdw;
        logic [31:0] resw;
        logic        stall, reg_write, mem_write, branch, jump, alu_src;
        logic [1:0]  rsrc;
        logic [2:0]  alu;
        logic        ill;
        logic [31:0] imm, rd1e, rd2e;
        logic [4:0]  rde, rs1e;
    } vec_t;

    e_t   cur_e;
    e_t   exp_q[$];
    vec_t tbl[14];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic string mnemonic(input logic [31:0] ins);
        logic [2:0] f3;
        f3 = ins[14:12];
        case (ins[6:0])
            7'h03: if (f3 == 3'd2) return "lw";
            7'h23: if (f3 == 3'd2) return "sw";
            7'h63: if (f3 == 3'd0) return "beq";
            7'h6f: return "jal";
            7'h13: begin
                if (f3 == 3'd0) return "addi";
                if (f3 == 3'd7) return "andi";
                if (f3 == 3'd6) return "ori";
                if (f3 == 3'd2) return "slti";
            end
            7'h33: begin
                if (f3 == 3'd0) begin
                    if (ins[30]) return "sub";
                    return "add";
                end
                if (!ins[30]) begin
                    if (f3 == 3'd7) return "and";
                    if (f3 == 3'd6) return "or";
                    if (f3 == 3'd2) return "slt";
                end
            end
            default: ;
        endcase
        return "bad";
    endfunction

    function automatic int imm_of(input string fmt, input logic [31:0] ins);
        int sgn;
        sgn = ins[31] ? 1 : 0;
        if (fmt == "I") return int'(ins[31:20]) - sgn * 4096;
        if (fmt == "S") return int'(ins[31:25]) * 32 + int'(ins[11:7]) - sgn * 4096;
        if (fmt == "B") return int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 +
                               int'(ins[11:8]) * 2 - sgn * 4096;
        if (fmt == "J") return int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 +
                               int'(ins[30:21]) * 2 - sgn * (1 << 20);
        return 0;
    endfunction

    function automatic e_t model_decode(input logic [31:0] ins);
        e_t    e;
        string m;
        e = '0;
        m = mnemonic(ins);
        case (m)
            "lw":   begin e.reg_write = 1; e.alu_src = 1; e.result_src = 2'b01; e.imm = imm_of("I", ins); end
            "sw":   begin e.mem_write = 1; e.alu_src = 1; e.imm = imm_of("S", ins); end
            "beq":  begin e.branch = 1; e.alu_ctrl = 3'b001; e.imm = imm_of("B", ins); end
            "jal":  begin e.jump = 1; e.reg_write = 1; e.result_src = 2'b10; e.imm = imm_of("J", ins); end
            "add":  e.reg_write = 1;
            "sub":  begin e.reg_write = 1; e.alu_ctrl = 3'b001; end
            "and":  begin e.reg_write = 1; e.alu_ctrl = 3'b010; end
            "or":   begin e.reg_write = 1; e.alu_ctrl = 3'b011; end
            "slt":  begin e.reg_write = 1; e.alu_ctrl = 3'b101; end
            "addi": begin e.reg_write = 1; e.alu_src = 1; e.imm = imm_of("I", ins); end
            "andi": begin e.reg_write = 1; e.alu_src = 1; e.alu_ctrl = 3'b010; e.imm = imm_of("I", ins); end
            "ori":  begin e.reg_write = 1; e.alu_src = 1; e.alu_ctrl = 3'b011; e.imm = imm_of("I", ins); end
            "slti": begin e.reg_write = 1; e.alu_src = 1; e.alu_ctrl = 3'b101; e.imm = imm_of("I", ins); end
            default: e.illegal = 1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] read_port(input logic [4:0] a, input logic [31:0] rf);
        if (RegWriteW && RdW != 0 && RdW == a) return ResultW;
        return rf;
    endfunction

    // ---------------- driver / scoreboard ----------------
    task automatic drive(input logic [31:0] ins, input logic f, input logic rw,
                         input logic [4:0] rdw, input logic [31:0] resw,
                         input logic [31:0] r1, input logic [31:0] r2);
        InstrD    = ins;
        FlushE    = f;
        RegWriteW = rw;
        RdW       = rdw;
        ResultW   = resw;
        RD1       = r1;
        RD2       = r2;
        PCD       = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
        PCPlus4D  = PCD + 32'd4;
    endtask

    task automatic compare_e(input string tag, input e_t e);
        check({tag, ".RegWriteE"},   RegWriteE,   e.reg_write);
        check({tag, ".MemWriteE"},   MemWriteE,   e.mem_write);
        check({tag, ".BranchE"},     BranchE,     e.branch);
        check({tag, ".JumpE"},       JumpE,       e.jump);
        check({tag, ".ALUSrcE"},     ALUSrcE,     e.alu_src);
        check({tag, ".ResultSrcE"},  ResultSrcE,  e.result_src);
        check({tag, ".ALUControlE"}, ALUControlE, e.alu_ctrl);
        check({tag, ".IllegalE"},    IllegalE,    e.illegal);
        if (!e.illegal) check({tag, ".ImmExtE"}, ImmExtE, e.imm);
        check({tag, ".RD1E"},        RD1E,        e.rd1);
        check({tag, ".RD2E"},        RD2E,        e.rd2);
        check({tag, ".PCE"},         PCE,         e.pc);
        check({tag, ".PCPlus4E"},    PCPlus4E,    e.pc4);
        check({tag, ".Rs1E"},        Rs1E,        e.rs1);
        check({tag, ".Rs2E"},        Rs2E,        e.rs2);
        check({tag, ".RdE"},         RdE,         e.rd);
    endtask

    // Inputs are already applied; checks StallD, predicts E, clocks, compares.
    task automatic step(input string tag, output logic got_stall);
        e_t         nxt;
        logic [4:0] a1, a2;
        logic       exp_stall;
        #1;
        a1 = InstrD[19:15];
        a2 = InstrD[24:20];
        check({tag, ".A1"}, A1, a1);
        check({tag, ".A2"}, A2, a2);
        exp_stall = (cur_e.result_src == 2'b01) && (cur_e.rd != 0) &&
                    (cur_e.rd == a1 || cur_e.rd == a2);
        got_stall = StallD;
        check({tag, ".StallD"}, StallD, exp_stall);
        if (FlushE || exp_stall) begin
            nxt = '0;
        end else begin
            nxt     = model_decode(InstrD);
            nxt.rd1 = read_port(a1, RD1);
            nxt.rd2 = read_port(a2, RD2);
            nxt.pc  = PCD;
            nxt.pc4 = PCPlus4D;
            nxt.rs1 = a1;
            nxt.rs2 = a2;
            nxt.rd  = InstrD[11:7];
        end
        exp_q.push_back(nxt);
        @(posedge clk);
        #1;
        cur_e = exp_q.pop_front();
        compare_e(tag, cur_e);
        @(negedge clk);
    endtask

    // ---------------- test ----------------
    initial begin
        logic        st;
        logic [31:0] w;
        logic [2:0]  f3s[4];
        logic        held;

        tbl[0]  = '{32'h00700293, 0, 0, 0, 0,            0, 1, 0, 0, 0, 1, 2'd0, 3'd0, 0, 32'h7,        0, 0, 5'd5, 5'd0};
        tbl[1]  = '{32'h003180B3, 0, 1, 3, 32'hDEADBEEF, 0, 1, 0, 0, 0, 0, 2'd0, 3'd0, 0, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 5'd1, 5'd3};
        tbl[2]  = '{32'h003180B3, 0, 1, 0, 32'hDEADBEEF, 0, 1, 0, 0, 0, 0, 2'd0, 3'd0, 0, 32'h0,        0, 0, 5'd1, 5'd3};
        tbl[3]  = '{32'h00012303, 0, 0, 0, 0,            0, 1, 0, 0, 0, 1, 2'd1, 3'd0, 0, 32'h0,        0, 0, 5'd6, 5'd2};
        tbl[4]  = '{32'h001303B3, 0, 0, 0, 0,            1, 0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 32'h0,        0, 0, 5'd0, 5'd0};
        tbl[5]  = '{32'h001303B3, 0, 0, 0, 0,            0, 1, 0, 0, 0, 0, 2'd0, 3'd0, 0, 32'h0,        0, 0, 5'd7, 5'd6};
        tbl[6]  = '{32'h00412423, 1, 0, 0, 0,            0, 0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 32'h0,        0, 0, 5'd0, 5'd0};
        tbl[7]  = '{32'h00412423, 0, 0, 0, 0,            0, 0, 1, 0, 0, 1, 2'd0, 3'd0, 0, 32'h8,        0, 0, 5'd8, 5'd2};
        tbl[8]  = '{32'h00012303, 0, 0, 0, 0,            0, 1, 0, 0, 0, 1, 2'd1, 3'd0, 0, 32'h0,        0, 0, 5'd6, 5'd2};
        tbl[9]  = '{32'h001303B3, 1, 0, 0, 0,            1, 0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 32'h0,        0, 0, 5'd0, 5'd0};
        tbl[10] = '{32'h001303B3, 0, 0, 0, 0,            0, 1, 0, 0, 0, 0, 2'd0, 3'd0, 0, 32'h0,        0, 0, 5'd7, 5'd6};
        tbl[11] = '{32'hFE208EE3, 0, 0, 0, 0,            0, 0, 0, 1, 0, 0, 2'd0, 3'd1, 0, 32'hFFFFFFFC, 0, 0, 5'd29, 5'd1};
        tbl[12] = '{32'h001000EF, 0, 0, 0, 0,            0, 1, 0, 0, 1, 0, 2'd2, 3'd0, 0, 32'h800,      0, 0, 5'd1, 5'd0};
        tbl[13] = '{32'h0000007F, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 2'd0, 3'd0, 1, 32'h0,        0, 0, 5'd0, 5'd0};

        // Clock/reset
        rst = 1'b1;
        drive(32'h0, 0, 0, 0, 0, 0, 0);
        cur_e = '0;
        repeat (2) @(negedge clk);
        compare_e("reset", '0);
        check("reset.StallD", StallD, 0);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            string tag;
            tag = $sformatf("t%0d", i);
            drive(tbl[i].ins, tbl[i].flush, tbl[i].rw, tbl[i].rdw, tbl[i].resw, 0, 0);
            step(tag, st);
            check({tag, ".tbl_stall"},  st,          tbl[i].stall);
            check({tag, ".tbl_rw"},     RegWriteE,   tbl[i].reg_write);
            check({tag, ".tbl_mw"},     MemWriteE,   tbl[i].mem_write);
            check({tag, ".tbl_br"},     BranchE,     tbl[i].branch);
            check({tag, ".tbl_jp"},     JumpE,       tbl[i].jump);
            check({tag, ".tbl_alusrc"}, ALUSrcE,     tbl[i].alu_src);
            check({tag, ".tbl_rsrc"},   ResultSrcE,  tbl[i].rsrc);
            check({tag, ".tbl_alu"},    ALUControlE, tbl[i].alu);
            check({tag, ".tbl_ill"},    IllegalE,    tbl[i].ill);
            check({tag, ".tbl_imm"},    ImmExtE,     tbl[i].imm);
            check({tag, ".tbl_rd1e"},   RD1E,        tbl[i].rd1e);
            check({tag, ".tbl_rd2e"},   RD2E,        tbl[i].rd2e);
            check({tag, ".tbl_rde"},    RdE,         tbl[i].rde);
            check({tag, ".tbl_rs1e"},   Rs1E,        tbl[i].rs1e);
        end

        // Asynchronous reset in the middle of a load-use stall
        drive(32'h00012303, 0, 0, 0, 0, 0, 0);
        step("rst_lw", st);
        drive(32'h001303B3, 0, 0, 0, 0, 0, 0);
        #1;
        check("rst.stall_before", StallD, 1);
        rst = 1'b1;
        #1;
        cur_e = '0;
        check("rst.stall_after", StallD, 0);
        compare_e("rst_mid", '0);
        @(negedge clk);
        rst = 1'b0;
        drive(32'h00700293, 0, 0, 0, 0, 0, 0);
        step("rst_addi", st);
        check("rst_addi.imm", ImmExtE, 32'd7);
        check("rst_addi.rd", RdE, 5'd5);
        check("rst_addi.alusrc", ALUSrcE, 1);
        check("rst_addi.rw", RegWriteE, 1);

        // Randomized traffic against the model
        f3s  = '{3'd0, 3'd7, 3'd6, 3'd2};
        held = 1'b0;
        w    = 32'h0;
        for (int n = 0; n < 600; n++) begin
            if (!held) begin
                w = $urandom();
                w[19:15] = 5'($urandom_range(0, 7));
                w[24:20] = 5'($urandom_range(0, 7));
                w[11:7]  = 5'($urandom_range(0, 7));
                case ($urandom_range(0, 8))
                    0, 1: begin w[6:0] = 7'h03; w[14:12] = 3'd2; end
                    2: begin w[6:0] = 7'h23; w[14:12] = 3'd2; end
                    3: begin w[6:0] = 7'h63; w[14:12] = 3'd0; end
                    4: w[6:0] = 7'h6f;
                    5, 6: begin
                        w[6:0]   = 7'h33;
                        w[31:25] = ($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00;
                        w[14:12] = f3s[$urandom_range(0, 3)];
                    end
                    7: begin w[6:0] = 7'h13; w[14:12] = f3s[$urandom_range(0, 3)]; end
                    default: ;
                endcase
            end
            drive(w, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), $urandom(), $urandom(), $urandom());
            step($sformatf("r%0d", n), st);
            held = st;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
